// File: rtl/core_run_ctrl_if.sv
// ============================================================================
// Module      : core_run_ctrl_if
// Description : Handshake and status bundle between a run controller and the
//               board/bench top that drives it and watches its verdict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_run_ctrl_if #(
  parameter int GW = 4,
  parameter int CW = 16
);
  logic          start;
  logic [GW-1:0] gout;
  logic          core_reset;
  logic          running;
  logic          done;
  logic          pass;
  logic          fail;
  logic          timeout;
  logic [CW-1:0] cycles;
  logic          log_rd;
  logic [GW-1:0] log_data;
  logic          log_empty;

  // Controller side
  modport slave (
    input  start, gout, log_rd,
    output core_reset, running, done, pass, fail, timeout, cycles,
           log_data, log_empty
  );

  // Top/bench side
  modport master (
    output start, gout, log_rd,
    input  core_reset, running, done, pass, fail, timeout, cycles,
           log_data, log_empty
  );
endinterface

`default_nettype wire

// File: rtl/core_run_ctrl.sv
// ============================================================================
// Module      : core_run_ctrl
// Description : Run controller for the selevy core. Holds the core in reset
//               for RST_CYCLES after a start pulse, then counts run cycles
//               while watching gout. The run ends on PASS_CODE, FAIL_CODE or
//               MAX_CYCLES, and the verdict is held until the next start.
//               Optional gout change log enabled by CORE_RUN_CTRL_LOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_run_ctrl #(
  parameter int            GW         = 4,
  parameter int            CW         = 16,
  parameter int            RST_CYCLES = 1,
  parameter int            MAX_CYCLES = 1000,
  parameter logic [GW-1:0] PASS_CODE  = 4'hF,
  parameter logic [GW-1:0] FAIL_CODE  = 4'hE,
  parameter int            LOG_DEPTH  = 8
) (
  input  wire logic        CLK,
  input  wire logic        reset,
  core_run_ctrl_if.slave   bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RST  = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [7:0]    c_RST_LOAD = 8'(RST_CYCLES - 1);
  localparam logic [CW-1:0] c_MAX      = CW'(MAX_CYCLES);

  logic [1:0]    r_state;
  logic [7:0]    r_rst_cnt;
  logic          r_core_reset;
  logic          r_running;
  logic          r_done;
  logic          r_pass;
  logic          r_fail;
  logic          r_timeout;
  logic [CW-1:0] r_cycles;
  logic [CW-1:0] w_cycles_inc;

  // Cycle counter sticks at all-ones instead of wrapping
  assign w_cycles_inc = (r_cycles == {CW{1'b1}}) ? r_cycles : r_cycles + CW'(1);

  // Run sequencer: state, core reset timing, cycle count and verdict flags
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_rst_cnt    <= 8'd0;
      r_core_reset <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycles     <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_core_reset <= 1'b1;
          if (bus.start) begin
            r_state   <= c_RST;
            r_rst_cnt <= c_RST_LOAD;
          end
        end
        c_RST: begin
          if (r_rst_cnt == 8'd0) begin
            r_state      <= c_RUN;
            r_core_reset <= 1'b0;
            r_running    <= 1'b1;
            r_cycles     <= CW'(1);
          end else begin
            r_rst_cnt <= r_rst_cnt - 8'd1;
          end
        end
        c_RUN: begin
          // Verdict priority: pass, then fail, then timeout
          if (bus.gout == PASS_CODE) begin
            r_state   <= c_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b1;
          end else if (bus.gout == FAIL_CODE) begin
            r_state   <= c_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_fail    <= 1'b1;
          end else if (r_cycles == c_MAX) begin
            r_state   <= c_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_cycles <= w_cycles_inc;
          end
        end
        c_DONE: begin
          // Core keeps running here so gout stays observable
          if (bus.start) begin
            r_state      <= c_RST;
            r_rst_cnt    <= c_RST_LOAD;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cycles     <= '0;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.core_reset = r_core_reset;
  assign bus.running    = r_running;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.fail       = r_fail;
  assign bus.timeout    = r_timeout;
  assign bus.cycles     = r_cycles;

`ifdef CORE_RUN_CTRL_LOG_EN
  localparam int             c_AW    = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam logic [c_AW:0]  c_DEPTH = (c_AW + 1)'(LOG_DEPTH);
  localparam logic [c_AW-1:0] c_LAST = c_AW'(LOG_DEPTH - 1);

  logic [GW-1:0]   r_mem [LOG_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic [GW-1:0]   r_gout_prev;
  logic            w_enter_rst;
  logic            w_change;
  logic            w_pop;
  logic            w_push;

  // cycles==1 only in the first RUN cycle, which is always logged
  assign w_change    = (r_state == c_RUN) &&
                       ((r_cycles == CW'(1)) || (bus.gout != r_gout_prev));
  assign w_enter_rst = bus.start && ((r_state == c_IDLE) || (r_state == c_DONE));
  assign w_pop       = bus.log_rd && (r_count != '0);
  // A full FIFO accepts a push only when a pop frees a slot in the same cycle
  assign w_push      = w_change && ((r_count != c_DEPTH) || w_pop);

  // Log pointers, occupancy and previous-gout tracker
  always_ff @(posedge CLK) begin
    if (reset || w_enter_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_gout_prev <= bus.gout;
    end else begin
      r_gout_prev <= bus.gout;
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Log storage; contents need no reset since occupancy gates every read
  always_ff @(posedge CLK) begin
    if (!reset && !w_enter_rst && w_push) begin
      r_mem[r_wr_ptr] <= bus.gout;
    end
  end

  assign bus.log_data  = r_mem[r_rd_ptr];
  assign bus.log_empty = (r_count == '0);
`else
  localparam int c_log_depth_unused = LOG_DEPTH;
  logic          w_log_rd_unused;

  assign w_log_rd_unused = bus.log_rd;
  assign bus.log_data    = '0;
  assign bus.log_empty   = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
// ============================================================================
// Module      : tb_core_run_ctrl
// Description : Self-checking bench for core_run_ctrl. Instance A uses
//               RST_CYCLES=1/MAX_CYCLES=1000, instance B RST_CYCLES=3/
//               MAX_CYCLES=40. Log checks depend on CORE_RUN_CTRL_LOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_run_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  core_run_ctrl_if #(.GW(4), .CW(16)) ifa ();
  core_run_ctrl_if #(.GW(4), .CW(16)) ifb ();

  core_run_ctrl #(
    .GW(4), .CW(16), .RST_CYCLES(1), .MAX_CYCLES(1000),
    .PASS_CODE(4'hF), .FAIL_CODE(4'hE), .LOG_DEPTH(8)
  ) dut_a (
    .CLK   (clk),
    .reset (rst),
    .bus   (ifa.slave)
  );

  core_run_ctrl #(
    .GW(4), .CW(16), .RST_CYCLES(3), .MAX_CYCLES(40),
    .PASS_CODE(4'hF), .FAIL_CODE(4'hE), .LOG_DEPTH(8)
  ) dut_b (
    .CLK   (clk),
    .reset (rst),
    .bus   (ifb.slave)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic [3:0]  g;
    logic        cr;
    logic        run;
    logic        dn;
    logic        ps;
    logic        fl;
    logic        to;
    logic [15:0] cyc;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait on instance A until cycles reaches the target, bounded
  task automatic wait_a(input logic [15:0] target, input int budget);
    int k = 0;
    while (ifa.cycles != target && k < budget) begin
      tick();
      k++;
    end
    chk($sformatf("A reach cycles %0d", target), 32'(ifa.cycles), 32'(target));
  endtask

  task automatic wait_b(input logic [15:0] target, input int budget);
    int k = 0;
    while (ifb.cycles != target && k < budget) begin
      tick();
      k++;
    end
    chk($sformatf("B reach cycles %0d", target), 32'(ifb.cycles), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst        = 1'b1;
    ifa.start  = 1'b0;
    ifa.gout   = 4'h0;
    ifa.log_rd = 1'b0;
    ifb.start  = 1'b0;
    ifb.gout   = 4'h0;
    ifb.log_rd = 1'b0;

    // {rst, start, gout} -> {core_reset, running, done, pass, fail, timeout, cycles} on instance B
    tv[0]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[1]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tv[5]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    tv[6]  = '{1'b0, 1'b0, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
    tv[7]  = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
    tv[8]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tv[12] = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tv[13] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[14] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[15] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[16] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tv[17] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    tv[18] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

    // Reset held two cycles; instance A must show reset values
    tick();
    tick();
    chk("A reset core_reset", 32'(ifa.core_reset), 32'd1);
    chk("A reset running",    32'(ifa.running),    32'd0);
    chk("A reset done",       32'(ifa.done),       32'd0);
    chk("A reset flags",      32'({ifa.pass, ifa.fail, ifa.timeout}), 32'd0);
    chk("A reset cycles",     32'(ifa.cycles),     32'd0);
    rst = 1'b0;

    // Table-driven vectors on instance B
    for (int i = 0; i < NV; i++) begin
      rst       = tv[i].rst;
      ifb.start = tv[i].st;
      ifb.gout  = tv[i].g;
      tick();
      chk($sformatf("vec%0d core_reset", i), 32'(ifb.core_reset), 32'(tv[i].cr));
      chk($sformatf("vec%0d running", i),    32'(ifb.running),    32'(tv[i].run));
      chk($sformatf("vec%0d done", i),       32'(ifb.done),       32'(tv[i].dn));
      chk($sformatf("vec%0d pass", i),       32'(ifb.pass),       32'(tv[i].ps));
      chk($sformatf("vec%0d fail", i),       32'(ifb.fail),       32'(tv[i].fl));
      chk($sformatf("vec%0d timeout", i),    32'(ifb.timeout),    32'(tv[i].to));
      chk($sformatf("vec%0d cycles", i),     32'(ifb.cycles),     32'(tv[i].cyc));
    end
    rst       = 1'b0;
    ifb.start = 1'b0;
    ifb.gout  = 4'h0;

    // A: RST_CYCLES=1 gives one core_reset cycle, then full-length timeout
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("A rst1 core_reset high", 32'(ifa.core_reset), 32'd1);
    chk("A rst1 running low",     32'(ifa.running),    32'd0);
    tick();
    chk("A run1 core_reset low",  32'(ifa.core_reset), 32'd0);
    chk("A run1 running",         32'(ifa.running),    32'd1);
    chk("A run1 cycles",          32'(ifa.cycles),     32'd1);
    k = 0;
    while (!ifa.done && k < 1100) begin
      tick();
      k++;
    end
    chk("A timeout latency", 32'(k),            32'd1000);
    chk("A timeout done",    32'(ifa.done),     32'd1);
    chk("A timeout flag",    32'(ifa.timeout),  32'd1);
    chk("A timeout pass",    32'(ifa.pass),     32'd0);
    chk("A timeout fail",    32'(ifa.fail),     32'd0);
    chk("A timeout cycles",  32'(ifa.cycles),   32'd1000);
    chk("A done core_reset", 32'(ifa.core_reset), 32'd0);
    tick();
    chk("A done holds cycles", 32'(ifa.cycles), 32'd1000);

    // A: pass at run cycle 37, later gout change leaves the verdict alone
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("A restart clears timeout", 32'(ifa.timeout), 32'd0);
    tick();
    wait_a(16'd37, 100);
    ifa.gout = 4'hF;
    tick();
    chk("A pass done",   32'(ifa.done),   32'd1);
    chk("A pass flags",  32'({ifa.pass, ifa.fail, ifa.timeout}), 32'b100);
    chk("A pass cycles", 32'(ifa.cycles), 32'd37);
    ifa.gout = 4'hE;
    tick();
    tick();
    chk("A pass hold flags",  32'({ifa.pass, ifa.fail, ifa.timeout}), 32'b100);
    chk("A pass hold cycles", 32'(ifa.cycles), 32'd37);
    ifa.gout = 4'h0;

    // A: reset at run cycle 10 returns to IDLE immediately
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    tick();
    wait_a(16'd10, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("A midreset core_reset", 32'(ifa.core_reset), 32'd1);
    chk("A midreset running",    32'(ifa.running),    32'd0);
    chk("A midreset cycles",     32'(ifa.cycles),     32'd0);
    chk("A midreset flags",      32'({ifa.done, ifa.pass, ifa.fail, ifa.timeout}), 32'd0);
    tick();
    chk("A idle stays idle", 32'(ifa.core_reset), 32'd1);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    tick();
    chk("A rerun cycles 1", 32'(ifa.cycles), 32'd1);
    repeat (4) tick();
    chk("A rerun cycles 5", 32'(ifa.cycles), 32'd5);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("A start in RUN ignored running", 32'(ifa.running),    32'd1);
    chk("A start in RUN ignored cycles",  32'(ifa.cycles),     32'd6);
    chk("A start in RUN core_reset",      32'(ifa.core_reset), 32'd0);

    // B: fail and timeout together at cycle 40 -> fail wins
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    repeat (3) tick();
    chk("B rst3 first run cycle", 32'(ifb.cycles), 32'd1);
    wait_b(16'd40, 60);
    ifb.gout = 4'hE;
    tick();
    chk("B fail vs timeout flags",  32'({ifb.pass, ifb.fail, ifb.timeout}), 32'b010);
    chk("B fail vs timeout cycles", 32'(ifb.cycles), 32'd40);
    chk("B fail vs timeout done",   32'(ifb.done),   32'd1);
    ifb.gout = 4'h0;

    // B: pass and timeout together at cycle 40 -> pass wins
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    repeat (3) tick();
    wait_b(16'd40, 60);
    ifb.gout = 4'hF;
    tick();
    chk("B pass vs timeout flags", 32'({ifb.pass, ifb.fail, ifb.timeout}), 32'b100);
    ifb.gout = 4'h0;

    // B: plain timeout at MAX_CYCLES=40
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    repeat (3) tick();
    wait_b(16'd40, 60);
    tick();
    chk("B timeout flags",  32'({ifb.pass, ifb.fail, ifb.timeout}), 32'b001);
    chk("B timeout cycles", 32'(ifb.cycles), 32'd40);

`ifdef CORE_RUN_CTRL_LOG_EN
    begin
      logic [3:0] gseq [14];
      logic [3:0] lexp [8];
      gseq = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
               4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
      lexp = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ifa.gout = 4'h0;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      chk("log cleared on start", 32'(ifa.log_empty), 32'd1);
      tick();
      for (int i = 0; i < 14; i++) begin
        ifa.gout = gseq[i];
        tick();
      end
      chk("log not empty", 32'(ifa.log_empty), 32'd0);
      ifa.log_rd = 1'b1;
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("log pop %0d", i), 32'(ifa.log_data), 32'(lexp[i]));
        tick();
      end
      ifa.log_rd = 1'b0;
      chk("log empty after pops", 32'(ifa.log_empty), 32'd1);
      ifa.log_rd = 1'b1;
      tick();
      ifa.log_rd = 1'b0;
      chk("log pop on empty ignored", 32'(ifa.log_empty), 32'd1);
    end
`else
    chk("log_empty tied high", 32'(ifa.log_empty), 32'd1);
    chk("log_data tied zero",  32'(ifa.log_data),  32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
